// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared state encoding and default field widths for the EX/MEM pipeline register.
package ex_mem_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;
endpackage

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with a skid slot for full-throughput valid/ready flow.
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush              : squash held and incoming entries
//   ex_valid/ex_ready  : upstream handshake; ex_* carry the entry
//   mem_valid/mem_ready: downstream handshake; mem_* driven straight from the main register
//   occupancy          : number of entries held (0..2)
module ex_mem_pipe #(
    parameter int DATA_W = ex_mem_pkg::DATA_W,
    parameter int REG_W  = ex_mem_pkg::REG_W,
    parameter int WB_W   = ex_mem_pkg::WB_W,
    parameter int M_W    = ex_mem_pkg::M_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_bpc,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_rd2,
    input  logic [WB_W-1:0]   ex_ctlwb,
    input  logic [M_W-1:0]    ex_ctlm,
    input  logic              ex_alu_zero,
    input  logic [REG_W-1:0]  ex_rd_mux,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_bpc,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_rd2,
    output logic [WB_W-1:0]   mem_ctlwb,
    output logic [M_W-1:0]    mem_ctlm,
    output logic              mem_alu_zero,
    output logic [REG_W-1:0]  mem_rd,
    output logic [1:0]        occupancy
);
    import ex_mem_pkg::*;

    localparam int ENT_W = 3*DATA_W + WB_W + M_W + 1 + REG_W;
    // Selects the ctlwb/ctlm bits so an emptied main register presents a bubble.
    localparam logic [ENT_W-1:0] CTL_MASK = {{(3*DATA_W){1'b0}}, {(WB_W+M_W){1'b1}}, {(REG_W+1){1'b0}}};

    state_e             state_q;
    logic [ENT_W-1:0]   main_q;
    logic [ENT_W-1:0]   skid_q;
    logic [ENT_W-1:0]   ex_ent;
    logic [ENT_W-1:0]   main_bubble;
    logic               in_fire;
    logic               out_fire;

    assign ex_ent      = {ex_bpc, ex_alu_out, ex_rd2, ex_ctlwb, ex_ctlm, ex_alu_zero, ex_rd_mux};
    assign main_bubble = main_q & ~CTL_MASK;
    assign ex_ready    = state_q != FULL;
    assign mem_valid   = state_q != EMPTY;
    assign occupancy   = state_q;
    assign in_fire     = ex_valid & ex_ready;
    assign out_fire    = mem_valid & mem_ready;
    assign {mem_bpc, mem_alu_out, mem_rd2, mem_ctlwb, mem_ctlm, mem_alu_zero, mem_rd} = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= main_bubble;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    main_q  <= ex_ent;
                    state_q <= BUSY;
                end
                BUSY: if (in_fire && out_fire) begin
                    main_q <= ex_ent;
                end else if (in_fire) begin
                    skid_q  <= ex_ent;
                    state_q <= FULL;
                end else if (out_fire) begin
                    main_q  <= main_bubble;
                    state_q <= EMPTY;
                end
                FULL: if (out_fire) begin
                    main_q  <= skid_q;
                    state_q <= BUSY;
                end
                default: begin
                    main_q  <= main_bubble;
                    state_q <= EMPTY;
                end
            endcase
        end
    end
endmodule
